// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI mode-3 responder.
package spi_responder_pkg;

  localparam int unsigned SPI_SIZE = 40;
  localparam int unsigned SPI_MODE = 3;
  localparam int unsigned SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_responder_sync_edge.sv
// Two-flop synchronizer with a third flop for rise/fall detection.
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q_o      = s2_q;
  assign rise_c_o = s2_q & ~s3_q;
  assign fall_c_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-3 responder: oversampled pins, fixed-length frames, preloaded reply word.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int unsigned SIZE = SPI_SIZE
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            sck_in,
  input  logic            cs_n_in,
  input  logic            mosi_in,
  output logic            miso_out,
  input  logic [SIZE-1:0] tx_data_in,
  input  logic            tx_load_in,
  output logic [SIZE-1:0] rx_data_out,
  output logic            rx_valid_out,
  output logic            frame_err_out,
  output logic            busy_out
);

  localparam int unsigned CNT_W = $clog2(SIZE + 2);

  logic sck_s, sck_rise, sck_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic mosi_s1_q, mosi_s2_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]  hold_q, hold_d;
  logic [SIZE-1:0]  rx_shift_q, rx_shift_d;
  logic [SIZE-1:0]  tx_shift_q, tx_shift_d;
  logic [SIZE-1:0]  rx_data_q, rx_data_d;
  logic             miso_q, miso_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  sync_edge #(.RST_VAL(1'b1)) u_sck_sync (
    .clk_i    (clk_in),
    .rst_ni   (rst_n_in),
    .d_i      (sck_in),
    .q_o      (sck_s),
    .rise_c_o (sck_rise),
    .fall_c_o (sck_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_i    (clk_in),
    .rst_ni   (rst_n_in),
    .d_i      (cs_n_in),
    .q_o      (cs_n_s),
    .rise_c_o (cs_rise),
    .fall_c_o (cs_fall)
  );

  // MOSI needs only the level, so it skips the edge-detect flop.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      mosi_s1_q <= mosi_in;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = tx_load_in ? tx_data_in : hold_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    rx_data_d   = done_q ? rx_shift_q : rx_data_q;
    rx_valid_d  = done_q;
    frame_err_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      // Let the sync chain flush so a frame already in flight is never picked up.
      ST_WAIT: begin
        if (cnt_q < CNT_W'(SETTLE_CYCLES)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (cs_n_s && sck_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_SHIFT;
          cnt_d      = '0;
          tx_shift_d = hold_q;
          miso_d     = hold_q[SIZE-1];
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = (cnt_q != CNT_W'(SIZE));
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[SIZE-2:0], mosi_s2_q};
          if (cnt_q != CNT_W'(SIZE + 1)) cnt_d = cnt_q + CNT_W'(1);
          done_d = (cnt_q == CNT_W'(SIZE - 1));
        end else if (sck_fall && (cnt_q != '0)) begin
          // Leading fall of bit 0 keeps the MSB already presented at CS fall.
          tx_shift_d = {tx_shift_q[SIZE-2:0], 1'b0};
          miso_d     = tx_shift_q[SIZE-2];
        end
      end
      default: state_d = ST_WAIT;
    endcase

    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      hold_q      <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign miso_out      = miso_q;
  assign rx_data_out   = rx_data_q;
  assign rx_valid_out  = rx_valid_q;
  assign frame_err_out = frame_err_q;
  assign busy_out      = busy_q;

endmodule
